// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-stream 1:2 packet demultiplexer.
//   AXIS_DATA_WIDTH : default stream data width
//   route_state_e   : routing FSM states (IDLE = between packets, BUSY = mid-packet)
//   PORT_1 / PORT_2 : encoding of the destination select
package axis_pkg;

  localparam int AXIS_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } route_state_e;

  localparam logic PORT_1 = 1'b0;
  localparam logic PORT_2 = 1'b1;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream skid buffer with fully registered outputs.
//   clk, reset          : clock, synchronous active-high reset
//   in_data/valid/last  : upstream beat; in_ready is registered (= !skid full)
//   out_data/valid/last : downstream beat held stable until out_ready
//   out_ready           : downstream ready
// One cycle from acceptance to out_valid; full throughput while out_ready
// stays high; when out_ready drops one extra beat lands in the skid register.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  main_valid_q, main_valid_d;
  logic                  main_last_q, main_last_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  skid_last_q, skid_last_d;
  logic                  ready_q;
  logic                  accept;
  logic                  main_free;

  // ready_q always equals !skid_valid_q outside reset, so a beat can never
  // arrive while the skid register is occupied.
  always_comb begin
    accept       = in_valid && ready_q;
    main_free    = !main_valid_q || out_ready;
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    main_last_d  = main_last_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    if (main_free) begin
      if (skid_valid_q) begin
        // Older skid beat goes first to preserve order.
        main_data_d  = skid_data_q;
        main_last_d  = skid_last_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_data_d = in_data;
          main_last_d = in_last;
        end
      end
    end else if (accept) begin
      skid_data_d  = in_data;
      skid_last_d  = in_last;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_data_q  <= '0;
      main_valid_q <= 1'b0;
      main_last_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      main_last_q  <= main_last_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      ready_q      <= !skid_valid_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = main_data_q;
  assign out_valid = main_valid_q;
  assign out_last  = main_last_q;

endmodule

// File: rtl/axis_demux_1_2.sv
// AXI-stream 1:2 packet router.
//   clk, reset                  : clock, synchronous active-high reset
//   sel                         : destination of next packet (0 = port 1, 1 = port 2)
//   s_data/valid/last, s_ready  : slave stream
//   m_data_x/valid_x/last_x     : master streams, m_ready_x from consumers
//   busy                        : a multi-beat packet is in progress
//   pkt_cnt_1/2                 : completed packets per port (wrapping)
// Destination is sampled on the first beat and locked until the last beat.
module axis_demux_1_2
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] m_data_1,
  output logic                  m_valid_1,
  input  logic                  m_ready_1,
  output logic                  m_last_1,
  output logic [DATA_WIDTH-1:0] m_data_2,
  output logic                  m_valid_2,
  input  logic                  m_ready_2,
  output logic                  m_last_2,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_1,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_2
);

  route_state_e         state_q, state_d;
  logic                 lock_q, lock_d;
  logic                 port;
  logic                 rdy_1, rdy_2;
  logic                 accept;
  logic [CNT_WIDTH-1:0] cnt_1_q, cnt_2_q;

  // Both buffer readies are registered; only this steering mux is live on sel.
  assign port    = (state_q == BUSY) ? lock_q : sel;
  assign s_ready = (port == PORT_2) ? rdy_2 : rdy_1;
  assign accept  = s_valid && s_ready;
  assign busy    = (state_q == BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lock_q  <= PORT_1;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (accept && !s_last) begin
          lock_d  = sel;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_1_q <= '0;
      cnt_2_q <= '0;
    end else begin
      if (m_valid_1 && m_ready_1 && m_last_1) cnt_1_q <= cnt_1_q + 1'b1;
      if (m_valid_2 && m_ready_2 && m_last_2) cnt_2_q <= cnt_2_q + 1'b1;
    end
  end

  assign pkt_cnt_1 = cnt_1_q;
  assign pkt_cnt_2 = cnt_2_q;

  axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf_1 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (s_data),
    .in_valid  (s_valid && (port == PORT_1)),
    .in_ready  (rdy_1),
    .in_last   (s_last),
    .out_data  (m_data_1),
    .out_valid (m_valid_1),
    .out_ready (m_ready_1),
    .out_last  (m_last_1)
  );

  axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf_2 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (s_data),
    .in_valid  (s_valid && (port == PORT_2)),
    .in_ready  (rdy_2),
    .in_last   (s_last),
    .out_data  (m_data_2),
    .out_valid (m_valid_2),
    .out_ready (m_ready_2),
    .out_last  (m_last_2)
  );

endmodule

// File: tb/tb_axis_demux_1_2.sv
// Directed self-checking bench for axis_demux_1_2.
module tb_axis_demux_1_2;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [7:0]  m_data_1, m_data_2;
  logic        m_valid_1, m_valid_2;
  logic        m_ready_1, m_ready_2;
  logic        m_last_1, m_last_2;
  logic        busy;
  logic [15:0] pkt_cnt_1, pkt_cnt_2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [8:0] q1[$];
  logic [8:0] q2[$];
  int         st1[$];
  int         acc_n, x2_n, maxocc, rdy_low_n, busy_seen, stab_bad;
  logic       pv1, pr1, pv2, pr2;
  logic [8:0] pd1, pd2;

  axis_demux_1_2 #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .m_data_1  (m_data_1),
    .m_valid_1 (m_valid_1),
    .m_ready_1 (m_ready_1),
    .m_last_1  (m_last_1),
    .m_data_2  (m_data_2),
    .m_valid_2 (m_valid_2),
    .m_ready_2 (m_ready_2),
    .m_last_2  (m_last_2),
    .busy      (busy),
    .pkt_cnt_1 (pkt_cnt_1),
    .pkt_cnt_2 (pkt_cnt_2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Observe handshakes mid-cycle; values are stable until the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid_1 && m_ready_1) begin
        q1.push_back({m_last_1, m_data_1});
        st1.push_back(cyc);
      end
      if (m_valid_2 && m_ready_2) begin
        q2.push_back({m_last_2, m_data_2});
        x2_n++;
      end
      if (s_valid && s_ready) acc_n++;
      if (acc_n - x2_n > maxocc) maxocc = acc_n - x2_n;
      if (!s_ready) rdy_low_n++;
      if (busy) busy_seen = 1;
      if (pv1 && !pr1 && (!m_valid_1 || {m_last_1, m_data_1} !== pd1)) stab_bad++;
      if (pv2 && !pr2 && (!m_valid_2 || {m_last_2, m_data_2} !== pd2)) stab_bad++;
      pv1 = m_valid_1; pr1 = m_ready_1; pd1 = {m_last_1, m_data_1};
      pv2 = m_valid_2; pr2 = m_ready_2; pd2 = {m_last_2, m_data_2};
    end else begin
      pv1 = 1'b0;
      pv2 = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    q1.delete(); q2.delete(); st1.delete();
    acc_n = 0; x2_n = 0; maxocc = 0; rdy_low_n = 0; busy_seen = 0; stab_bad = 0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick(2);
    reset = 1'b0;
    clear_obs();
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] d, input logic l, input logic s);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    sel     = s;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  initial begin
    logic [8:0] e1[$];
    logic [8:0] e2[$];

    // ---------------- reset with s_valid held high ----------------
    reset = 1'b1; s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0; sel = 1'b0;
    m_ready_1 = 1'b1; m_ready_2 = 1'b1;
    clear_obs();
    tick(1);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    tick(1);
    chk("rst_s_ready2", {31'd0, s_ready}, 32'd0);
    chk("rst_mv1", {31'd0, m_valid_1}, 32'd0);
    chk("rst_mv2", {31'd0, m_valid_2}, 32'd0);
    chk("rst_data1", {24'd0, m_data_1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt1", {16'd0, pkt_cnt_1}, 32'd0);
    chk("rst_cnt2", {16'd0, pkt_cnt_2}, 32'd0);
    reset = 1'b0; s_valid = 1'b0;
    tick(1);
    chk("post_rst_ready", {31'd0, s_ready}, 32'd1);
    chk("post_rst_mv1", {31'd0, m_valid_1}, 32'd0);
    chk("post_rst_mv2", {31'd0, m_valid_2}, 32'd0);

    // ---------------- straight 4-beat packet to port 1 ----------------
    do_reset();
    send(8'h11, 1'b0, 1'b0);
    chk("lat_mv1", {31'd0, m_valid_1}, 32'd1);
    chk("lat_md1", {24'd0, m_data_1}, 32'h11);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    send(8'h12, 1'b0, 1'b0);
    send(8'h13, 1'b0, 1'b0);
    send(8'h14, 1'b1, 1'b0);
    tick(3);
    e1 = '{9'h011, 9'h012, 9'h013, 9'h114};
    chk("str_n1", q1.size(), 4);
    for (int i = 0; i < 4; i++) chk("str_beat", {23'd0, q1[i]}, {23'd0, e1[i]});
    chk("str_b2b", st1[3] - st1[0], 3);
    chk("str_n2", q2.size(), 0);
    chk("str_cnt1", {16'd0, pkt_cnt_1}, 32'd1);
    chk("str_cnt2", {16'd0, pkt_cnt_2}, 32'd0);

    // ---------------- sel change mid-packet ----------------
    do_reset();
    send(8'h21, 1'b0, 1'b0);
    chk("mid_busy1", {31'd0, busy}, 32'd1);
    send(8'h22, 1'b0, 1'b0);
    send(8'h23, 1'b0, 1'b1);
    send(8'h24, 1'b0, 1'b1);
    chk("mid_busy4", {31'd0, busy}, 32'd1);
    send(8'h25, 1'b1, 1'b1);
    chk("mid_busy5", {31'd0, busy}, 32'd0);
    send(8'hA0, 1'b0, 1'b1);
    send(8'hA1, 1'b1, 1'b1);
    tick(3);
    e1 = '{9'h021, 9'h022, 9'h023, 9'h024, 9'h125};
    e2 = '{9'h0A0, 9'h1A1};
    chk("mid_n1", q1.size(), 5);
    for (int i = 0; i < 5; i++) chk("mid_p1", {23'd0, q1[i]}, {23'd0, e1[i]});
    chk("mid_n2", q2.size(), 2);
    for (int i = 0; i < 2; i++) chk("mid_p2", {23'd0, q2[i]}, {23'd0, e2[i]});
    chk("mid_cnt1", {16'd0, pkt_cnt_1}, 32'd1);
    chk("mid_cnt2", {16'd0, pkt_cnt_2}, 32'd1);

    // ---------------- backpressure on port 2 ----------------
    do_reset();
    fork
      begin
        for (int i = 1; i <= 8; i++)
          send(8'h30 + 8'(i), (i == 8), 1'b1);
      end
      begin
        tick(3);
        m_ready_2 = 1'b0;
        tick(4);
        m_ready_2 = 1'b1;
      end
    join
    tick(4);
    chk("bp_n2", q2.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("bp_beat", {23'd0, q2[i]}, {23'd0, (i == 7), 8'h31 + 8'(i)});
    chk("bp_maxocc", maxocc, 2);
    chk("bp_rdy_dropped", {31'd0, (rdy_low_n > 0)}, 32'd1);
    chk("bp_stable", stab_bad, 0);
    chk("bp_n1", q1.size(), 0);
    chk("bp_cnt2", {16'd0, pkt_cnt_2}, 32'd1);

    // ---------------- single-beat interleave, port 1 stalled ----------------
    do_reset();
    m_ready_1 = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(8'(i), 1'b1, ((i % 2) == 0));
      end
      begin
        tick(3);
        m_ready_1 = 1'b1;
      end
    join
    tick(4);
    e1 = '{9'h101, 9'h103, 9'h105};
    e2 = '{9'h102, 9'h104, 9'h106};
    chk("il_n1", q1.size(), 3);
    chk("il_n2", q2.size(), 3);
    for (int i = 0; i < 3; i++) chk("il_p1", {23'd0, q1[i]}, {23'd0, e1[i]});
    for (int i = 0; i < 3; i++) chk("il_p2", {23'd0, q2[i]}, {23'd0, e2[i]});
    chk("il_busy", busy_seen, 0);
    chk("il_stable", stab_bad, 0);
    chk("il_cnt1", {16'd0, pkt_cnt_1}, 32'd3);
    chk("il_cnt2", {16'd0, pkt_cnt_2}, 32'd3);

    // ---------------- reset in the middle of a packet ----------------
    do_reset();
    m_ready_1 = 1'b0;
    send(8'h41, 1'b0, 1'b0);
    send(8'h42, 1'b0, 1'b0);
    chk("mr_mv1_before", {31'd0, m_valid_1}, 32'd1);
    chk("mr_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick(1);
    chk("mr_mv1", {31'd0, m_valid_1}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_s_ready", {31'd0, s_ready}, 32'd0);
    reset = 1'b0;
    m_ready_1 = 1'b1;
    send(8'h51, 1'b0, 1'b1);
    send(8'h52, 1'b1, 1'b1);
    tick(3);
    e2 = '{9'h051, 9'h152};
    chk("mr_n1", q1.size(), 0);
    chk("mr_n2", q2.size(), 2);
    for (int i = 0; i < 2; i++) chk("mr_p2", {23'd0, q2[i]}, {23'd0, e2[i]});
    chk("mr_cnt1", {16'd0, pkt_cnt_1}, 32'd0);
    chk("mr_cnt2", {16'd0, pkt_cnt_2}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
